// File: rtl/shift_pkg.sv
// Shared definitions for the serial shift path (transmit and receive blocks).
// State encodings and the legal word-length range live here so both ends agree.
package shift_pkg;

    typedef logic [0:0] shift_state_t;

    localparam shift_state_t ST_IDLE  = 1'b0;
    localparam shift_state_t ST_SHIFT = 1'b1;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/shift_bit_cnt.sv
// Modulo-WIDTH bit counter with synchronous clear, load-to-zero and terminal count.
module shift_bit_cnt
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          zero,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == CW'(WIDTH - 1));

    // Explicit wrap on terminal count so non-power-of-two widths stay modulo WIDTH.
    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (zero) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: valid/ready word load, one bit per clock out,
// with per-bit valid and last-bit marker; back-to-back words stream without a gap.
//
//   state    | meaning
//   ST_IDLE  | no frame on so; load_ready high
//   ST_SHIFT | frame bit on so; load_ready high only on the last bit
module piso_shift_tx
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    if (!width_legal(WIDTH)) begin : g_width_check
        $error("piso_shift_tx: WIDTH must be within 2..32");
    end

    shift_state_t     state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_shifted;
    logic [CW-1:0]    cnt;
    logic             tc;
    logic             hs;
    logic             first_bit;
    logic             next_bit;

    assign busy       = (state == ST_SHIFT);
    assign load_ready = !clear && ((state == ST_IDLE) || tc);
    assign hs         = load_valid && load_ready;

    always_comb begin
        if (MSB_FIRST) begin
            first_bit     = load_data[WIDTH-1];
            next_bit      = shreg[WIDTH-2];
            shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
        end else begin
            first_bit     = load_data[0];
            next_bit      = shreg[1];
            shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
        end
    end

    // A handshake zeroes the counter; otherwise it advances every SHIFT cycle and
    // wraps to zero on the final bit, leaving it at zero when the FSM drops to IDLE.
    shift_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk   (clk),
        .clear (clear),
        .zero  (hs),
        .inc   (busy),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            so       <= 1'b0;
            so_valid <= 1'b0;
            so_last  <= 1'b0;
        end else if (hs) begin
            state    <= ST_SHIFT;
            shreg    <= load_data;
            so       <= first_bit;
            so_valid <= 1'b1;
            so_last  <= 1'b0;
        end else if (state == ST_SHIFT) begin
            if (tc) begin
                state    <= ST_IDLE;
                shreg    <= '0;
                so       <= 1'b0;
                so_valid <= 1'b0;
                so_last  <= 1'b0;
            end else begin
                shreg    <= shreg_shifted;
                so       <= next_bit;
                so_last  <= (cnt == CW'(WIDTH - 2));
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an 8-bit MSB-first and a 4-bit LSB-first instance,
// table-driven frames plus hand-written corner sequences, checked by a bit scoreboard.
module tb_piso_shift_tx;

    logic       clk;
    logic       clear;
    logic       lv8, lv4;
    logic [7:0] d8;
    logic [3:0] d4;
    logic       ready8, so8, sov8, sol8, busy8;
    logic       ready4, so4, sov4, sol4, busy4;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic b;
        logic last;
    } sb_t;

    sb_t q8[$];
    sb_t q4[$];
    bit  hs8_fired, hs4_fired;

    // bits: expected serial order, first-sent bit in [7]
    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;
        bit         b2b;
    } vec8_t;

    vec8_t tbl[6];

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
        .clk        (clk),
        .clear      (clear),
        .load_valid (lv8),
        .load_data  (d8),
        .load_ready (ready8),
        .so         (so8),
        .so_valid   (sov8),
        .so_last    (sol8),
        .busy       (busy8)
    );

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (
        .clk        (clk),
        .clear      (clear),
        .load_valid (lv4),
        .load_data  (d4),
        .load_ready (ready4),
        .so         (so4),
        .so_valid   (sov4),
        .so_last    (sol4),
        .busy       (busy4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input sb_t q[$], output sb_t qo[$],
                             input logic so_a, input logic sov_a, input logic sol_a,
                             input logic busy_a);
        sb_t e;
        qo = q;
        if (qo.size() > 0) begin
            e = qo.pop_front();
            chk({tag, ".so_valid"}, sov_a, 1'b1);
            chk({tag, ".so"}, so_a, e.b);
            chk({tag, ".so_last"}, sol_a, e.last);
            chk({tag, ".busy"}, busy_a, 1'b1);
        end else begin
            chk({tag, ".so_valid"}, sov_a, 1'b0);
            chk({tag, ".so"}, so_a, 1'b0);
            chk({tag, ".so_last"}, sol_a, 1'b0);
            chk({tag, ".busy"}, busy_a, 1'b0);
        end
    endtask

    // One clock: model ready and handshake before the edge, check outputs after it.
    task automatic tick(input logic [7:0] f8, input logic [3:0] f4);
        bit  er8, er4;
        sb_t tmp[$];
        @(negedge clk);
        er8 = !clear && (q8.size() == 0);
        er4 = !clear && (q4.size() == 0);
        chk("w8.load_ready", ready8, er8);
        chk("w4.load_ready", ready4, er4);
        if (clear) begin
            q8.delete();
            q4.delete();
        end
        hs8_fired = lv8 && er8;
        hs4_fired = lv4 && er4;
        if (hs8_fired)
            for (int k = 0; k < 8; k++) q8.push_back('{b: f8[7-k], last: (k == 7)});
        if (hs4_fired)
            for (int k = 0; k < 4; k++) q4.push_back('{b: f4[3-k], last: (k == 3)});
        @(posedge clk);
        #1;
        check_out("w8", q8, tmp, so8, sov8, sol8, busy8);
        q8 = tmp;
        check_out("w4", q4, tmp, so4, sov4, sol4, busy4);
        q4 = tmp;
    endtask

    task automatic wait_hs8(input logic [7:0] f8);
        int n = 0;
        hs8_fired = 1'b0;
        while (!hs8_fired && n < 40) begin
            tick(f8, 4'h0);
            n++;
        end
        chk("w8.handshake_timeout", hs8_fired, 1'b1);
    endtask

    task automatic wait_hs4(input logic [3:0] f4);
        int n = 0;
        hs4_fired = 1'b0;
        while (!hs4_fired && n < 40) begin
            tick(8'h00, f4);
            n++;
        end
        chk("w4.handshake_timeout", hs4_fired, 1'b1);
    endtask

    // Run out the current frames, then one more cycle to see so_valid drop.
    task automatic drain();
        int n = 0;
        while ((q8.size() > 0 || q4.size() > 0) && n < 40) begin
            tick(8'h00, 4'h0);
            n++;
        end
        chk("drain_timeout", (q8.size() == 0 && q4.size() == 0), 1'b1);
        tick(8'h00, 4'h0);
    endtask

    initial begin
        tbl[0] = '{data: 8'hA5, bits: 8'b10100101, b2b: 1'b0};
        tbl[1] = '{data: 8'hA5, bits: 8'b10100101, b2b: 1'b1};
        tbl[2] = '{data: 8'h3C, bits: 8'b00111100, b2b: 1'b0};
        tbl[3] = '{data: 8'hFF, bits: 8'b11111111, b2b: 1'b1};
        tbl[4] = '{data: 8'h00, bits: 8'b00000000, b2b: 1'b1};
        tbl[5] = '{data: 8'h81, bits: 8'b10000001, b2b: 1'b0};

        // Clear held with load_valid high: nothing captured, ready stays low.
        clear = 1'b1;
        lv8   = 1'b1;
        d8    = 8'hA5;
        lv4   = 1'b1;
        d4    = 4'b0001;
        repeat (3) tick(8'hA5, 4'b1000);
        clear = 1'b0;
        lv8   = 1'b0;
        lv4   = 1'b0;
        tick(8'h00, 4'h0);

        for (int i = 0; i < 6; i++) begin
            d8  = tbl[i].data;
            lv8 = 1'b1;
            wait_hs8(tbl[i].bits);
            if (!tbl[i].b2b) begin
                lv8 = 1'b0;
                drain();
            end
        end

        // Load attempt mid-frame is ignored.
        d8  = 8'hA5;
        lv8 = 1'b1;
        wait_hs8(8'b10100101);
        lv8 = 1'b0;
        tick(8'h00, 4'h0);
        tick(8'h00, 4'h0);
        d8  = 8'hFF;
        lv8 = 1'b1;
        tick(8'hFF, 4'h0);
        lv8 = 1'b0;
        drain();

        // Clear after three bits drops the frame; a fresh word then goes out intact.
        d8  = 8'hA5;
        lv8 = 1'b1;
        wait_hs8(8'b10100101);
        lv8 = 1'b0;
        tick(8'h00, 4'h0);
        tick(8'h00, 4'h0);
        clear = 1'b1;
        tick(8'h00, 4'h0);
        clear = 1'b0;
        d8  = 8'h81;
        lv8 = 1'b1;
        wait_hs8(8'b10000001);
        lv8 = 1'b0;
        drain();

        // LSB-first 4-bit instance: single frame, then two back-to-back.
        d4  = 4'b0001;
        lv4 = 1'b1;
        wait_hs4(4'b1000);
        lv4 = 1'b0;
        drain();
        d4  = 4'b1010;
        lv4 = 1'b1;
        wait_hs4(4'b0101);
        d4  = 4'b0110;
        wait_hs4(4'b0110);
        lv4 = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter: accepts a WIDTH-bit word over a valid/ready load handshake and drives it out one bit per clock on a serial line, with a per-bit valid strobe and a last-bit marker. It is the transmit end of the team's serial shift path; its `so`/`so_valid` output feeds a serial-in shift register or deserializer on the same clock. Back-to-back words stream with no idle cycle between frames.

## Interface
- `WIDTH`, 8: word length in bits; legal range 2 to 32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted first (left shift); 0 = bit 0 is shifted first (right shift).

- `clk` input 1: single clock; all state updates on the rising edge.
- `clear` input 1: reset, synchronous, active-high; overrides every other input.
- `load_valid` input 1: `load_data` holds a word to transmit.
- `load_data` input WIDTH: parallel word; sampled only on handshake.
- `load_ready` output 1: block can accept a word this cycle (combinational from state).
- `so` output 1: serial data out (registered).
- `so_valid` output 1: `so` carries a frame bit this cycle (registered).
- `so_last` output 1: current `so` bit is the final bit of the frame (registered).
- `busy` output 1: high in SHIFT state.

## Operation
- States: IDLE, SHIFT. Encoding 1'b0 and 1'b1.
- Internal: `shreg[WIDTH-1:0]`, `cnt[$clog2(WIDTH)-1:0]` counting bits already presented.
- Handshake fires on a rising edge where `load_valid && load_ready && !clear`.
- `load_ready` = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1), forced 0 while `clear` is high.
- IDLE + handshake: shreg <= load_data, so <= first bit, so_valid <= 1, so_last <= 0, cnt <= 0, go to SHIFT.
- SHIFT, cnt < WIDTH-1: shift shreg toward the output end, so <= next bit, cnt <= cnt+1, so_last <= (cnt+1 == WIDTH-1).
- SHIFT, cnt == WIDTH-1 (last bit on `so`):
  - With handshake: reload exactly as from IDLE. Stay in SHIFT, no gap.
  - Without handshake: so <= 0, so_valid <= 0, so_last <= 0, go to IDLE.
- `load_valid` while `load_ready` is low is ignored. `load_data` is not captured, and the source must hold it.
- Zero-fill: bits vacated by shifting are 0. `so` is 0 whenever `so_valid` is 0.
- `clear` at any point, including mid-frame: next edge gives state IDLE, shreg 0, cnt 0, so 0, so_valid 0, so_last 0, busy 0. The partial frame is dropped, and no handshake is accepted on that edge.

## Timing
- Reset values: so=0, so_valid=0, so_last=0, busy=0. `load_ready` is 0 while `clear` is high and 1 in the first cycle after.
- Latency: the handshake at edge N puts the first bit on `so` after edge N. Bit k (0-based, send order) is valid after edge N+k.
- A frame occupies exactly WIDTH consecutive `so_valid` cycles. `so_last` is high only in the WIDTH-th.
- Throughput: 1 bit/clock sustained. Words accepted every WIDTH cycles when `load_valid` is held high.
- Minimum gap between frames is 0 cycles. Without a new word, `so_valid` drops in the cycle after `so_last`.

## Structure
- Shared package/header `shift_pkg`: state encodings (`ST_IDLE`, `ST_SHIFT`) and the WIDTH legality check constant. These are shared with the receive-side shift blocks.
- One natural sub-module: `shift_bit_cnt`, a modulo-WIDTH bit counter with synchronous clear, load-to-zero and terminal-count output. The top level holds the FSM, shift register and handshake.
- Expected size: about 150 RTL lines total.

## Test plan
- WIDTH=8, MSB_FIRST=1. After clear, load 8'hA5 -> `so` = 1,0,1,0,0,1,0,1 on the 8 cycles after the handshake. `so_last` is high only on the 8th bit, then so_valid=0, load_ready=1.
- Back-to-back: load 8'hA5 then 8'h3C with `load_valid` held high -> 16 contiguous so_valid cycles reading 10100101 00111100, with `so_last` at bits 8 and 16 and load_ready high only in those two cycles.
- Load attempt mid-frame: pulse load_valid with 8'hFF during bit 3 of 8'hA5 -> ignored. The serial stream is unchanged, and the block returns to IDLE after 8 bits.
- Clear mid-frame: assert clear after 3 bits of 8'hA5 -> next cycle so=0, so_valid=0, busy=0. A fresh load of 8'h81 then emits 1,0,0,0,0,0,0,1.
- MSB_FIRST=0, WIDTH=4: load 4'b0001 -> `so` = 1,0,0,0, with so_last on the 4th bit.
- Reset state: clear held 3 cycles with load_valid=1 -> no capture. so, so_valid, so_last and busy are 0 and load_ready is 0 throughout.
